// File: rtl/div_pkg.sv
// div_pkg: shared widths, divide-by-zero result and FSM state encoding for div_share_ctrl
package div_pkg;
    localparam int DIV_W = 32;
    localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} div_state_t;
endpackage

// File: rtl/div_share_ctrl_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from last+1
// req: request vector; last: previous winner; gnt: one-hot winner (0 if none); idx: winner index
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx
);
    logic [ID_W-1:0] k;
    // Walk from the lowest priority down so the highest-priority hit is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        k   = '0;
        for (int i = N; i >= 1; i--) begin
            k = ID_W'((int'(last) + i) % N);
            if (req[k]) begin
                gnt = N'(1) << k;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/divider_unsigned.sv
// divider_unsigned: combinational 32-bit unsigned divider
// i_dividend, i_divisor: operands; o_quotient, o_remainder: results (undefined for divisor 0)
module divider_unsigned (
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);
    assign o_quotient  = i_dividend / i_divisor;
    assign o_remainder = i_dividend % i_divisor;
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sharing of one unsigned divider between NUM_REQ requesters
// i_clk/i_rst: clock, sync active-high reset
// i_req_valid/o_req_ready, i_req_dividend/i_req_divisor: per-requester request channel (packed 32b lanes)
// o_rsp_valid/i_rsp_ready: per-requester response channel; o_rsp_quotient/remainder/div_by_zero: shared result
// o_busy: an operation is in flight
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*DIV_W-1:0] i_req_dividend,
    input  logic [NUM_REQ*DIV_W-1:0] i_req_divisor,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    input  logic [NUM_REQ-1:0]       i_rsp_ready,
    output logic [DIV_W-1:0]         o_rsp_quotient,
    output logic [DIV_W-1:0]         o_rsp_remainder,
    output logic                     o_rsp_div_by_zero,
    output logic                     o_busy
);
    div_state_t         state;
    logic [ID_W-1:0]    rr_last, grant, pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [DIV_W-1:0]   op_dividend, op_divisor, div_q, div_r;

    rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req  (i_req_valid),
        .last (rr_last),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    divider_unsigned u_div (
        .i_dividend  (op_dividend),
        .i_divisor   (op_divisor),
        .o_quotient  (div_q),
        .o_remainder (div_r)
    );

    assign o_req_ready = (state == IDLE && !i_rst) ? pick_gnt : '0;
    assign o_busy      = state != IDLE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            rr_last           <= ID_W'(NUM_REQ - 1);
            grant             <= '0;
            op_dividend       <= '0;
            op_divisor        <= '0;
            o_rsp_valid       <= '0;
            o_rsp_quotient    <= '0;
            o_rsp_remainder   <= '0;
            o_rsp_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|pick_gnt) begin
                    op_dividend <= i_req_dividend[int'(pick_idx)*DIV_W +: DIV_W];
                    op_divisor  <= i_req_divisor[int'(pick_idx)*DIV_W +: DIV_W];
                    grant       <= pick_idx;
                    state       <= EXEC;
                end
                // Divide-by-zero result is defined here, ignoring whatever the divider produces.
                EXEC: begin
                    o_rsp_quotient    <= op_divisor == '0 ? DIV0_QUOTIENT : div_q;
                    o_rsp_remainder   <= op_divisor == '0 ? op_dividend : div_r;
                    o_rsp_div_by_zero <= op_divisor == '0;
                    o_rsp_valid       <= NUM_REQ'(1) << grant;
                    state             <= RESP;
                end
                RESP: if (i_rsp_ready[grant]) begin
                    rr_last     <= grant;
                    o_rsp_valid <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
